// File: rtl/uart_rx_os16.sv
// uart_rx_os16 - 16x oversampling UART receiver.
//
// Deserialises the asynchronous rx_in line into a parallel word using the
// shared 5-bit line-format word and the 16x baud tick. Start bits are
// qualified at mid-bit. Data, parity and stop bits are sampled every 16
// ticks after that. A completed frame is presented with a one-cycle
// rx_ready strobe.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   ctrl_word  [1:0] data bits (5..8), [2] two stop bits, [3] parity enable,
//              [4] parity type (1 = even, 0 = odd); latched at start detect
//   baud16_en  one-clk tick at 16x the baud rate
//   rx_in      asynchronous serial line, idle high
//   rx_data    received word, right-justified, upper bits zero
//   rx_ready   one-clk pulse when rx_data / error flags are updated
//   rx_error   parity_err | frame_err
//   parity_err parity mismatch on the last frame
//   frame_err  a stop bit sampled low on the last frame
//   rx_busy    receiver is inside a frame (state other than IDLE)
module uart_rx_os16 #(
  parameter int SYNC_STAGES = 2,
  parameter int MID_TICK    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ctrl_word,
  input  logic       baud16_en,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_error,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam logic [3:0] MID = 4'(MID_TICK);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic [3:0]             tcnt, tcnt_n;
  logic [2:0]             bidx, bidx_n;
  logic [1:0]             scnt, scnt_n;
  logic [7:0]             shreg, shreg_n;
  logic                   par, par_n;
  logic                   perr, perr_n;
  logic                   ferr, ferr_n;
  logic [4:0]             cfg, cfg_n;
  logic                   armed, armed_n;
  logic                   complete;

  // Shift register fills from the MSB, so an N-bit word ends up in the top
  // N bits and is shifted down by 8-N.
  function automatic logic [7:0] justify(input logic [7:0] sh, input logic [1:0] nsel);
    case (nsel)
      2'b00:   return {3'b000, sh[7:3]};
      2'b01:   return {2'b00,  sh[7:2]};
      2'b10:   return {1'b0,   sh[7:1]};
      default: return sh;
    endcase
  endfunction

  assign rx_s    = sync[SYNC_STAGES-1];
  assign rx_busy = (state != IDLE);

  always_comb begin
    state_n  = state;
    tcnt_n   = tcnt;
    bidx_n   = bidx;
    scnt_n   = scnt;
    shreg_n  = shreg;
    par_n    = par;
    perr_n   = perr;
    ferr_n   = ferr;
    cfg_n    = cfg;
    armed_n  = armed;
    complete = 1'b0;
    if (baud16_en) begin
      case (state)
        IDLE: begin
          if (rx_s) begin
            armed_n = 1'b1;
          end else if (armed) begin
            cfg_n   = ctrl_word;
            tcnt_n  = 4'd0;
            scnt_n  = 2'd0;
            par_n   = 1'b0;
            perr_n  = 1'b0;
            ferr_n  = 1'b0;
            state_n = START;
          end
        end
        START: begin
          tcnt_n = tcnt + 4'd1;
          if (tcnt == MID) begin
            if (rx_s) begin
              state_n = IDLE;           // glitch, not a real start bit
            end else begin
              tcnt_n  = 4'd0;
              bidx_n  = 3'd0;
              state_n = DATA;
            end
          end
        end
        DATA: begin
          tcnt_n = tcnt + 4'd1;
          if (tcnt == 4'd15) begin
            shreg_n = {rx_s, shreg[7:1]};
            par_n   = par ^ rx_s;
            bidx_n  = bidx + 3'd1;
            if (bidx == {1'b1, cfg[1:0]})
              state_n = cfg[3] ? PARITY : STOP;
          end
        end
        PARITY: begin
          tcnt_n = tcnt + 4'd1;
          if (tcnt == 4'd15) begin
            // Even parity wants a zero total over data+parity, odd wants one.
            perr_n  = par ^ rx_s ^ ~cfg[4];
            state_n = STOP;
          end
        end
        STOP: begin
          tcnt_n = tcnt + 4'd1;
          if (tcnt == 4'd15) begin
            ferr_n = ferr | ~rx_s;
            if (cfg[2] && scnt == 2'd0) begin
              scnt_n = 2'd1;
            end else begin
              complete = 1'b1;
              state_n  = IDLE;
              // A framing error disarms start detection until the line has
              // been seen high, so a break yields one frame, not a stream.
              armed_n  = ~ferr_n;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '1;
      state <= IDLE;
      tcnt  <= 4'd0;
      bidx  <= 3'd0;
      scnt  <= 2'd0;
      shreg <= 8'd0;
      par   <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      cfg   <= 5'd0;
      armed <= 1'b1;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], rx_in};
      state <= state_n;
      tcnt  <= tcnt_n;
      bidx  <= bidx_n;
      scnt  <= scnt_n;
      shreg <= shreg_n;
      par   <= par_n;
      perr  <= perr_n;
      ferr  <= ferr_n;
      cfg   <= cfg_n;
      armed <= armed_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= 8'd0;
      rx_ready   <= 1'b0;
      rx_error   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_ready <= complete;
      if (complete) begin
        rx_data    <= justify(shreg, cfg[1:0]);
        parity_err <= perr;
        frame_err  <= ferr_n;
        rx_error   <= perr | ferr_n;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16 - self-checking bench for uart_rx_os16.
// Frames are bit-banged at 64 clk per bit (tick every 4 clk). Expected
// results are queued when a frame is sent and checked by a monitor when
// rx_ready fires; scenario tasks check counts, latency and flags inline.
module tb_uart_rx_os16;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ctrl_word;
  logic       baud16_en;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_ready, rx_error, parity_err, frame_err, rx_busy;

  uart_rx_os16 #(.SYNC_STAGES(2), .MID_TICK(7)) dut (
    .clk(clk), .rst(rst), .ctrl_word(ctrl_word), .baud16_en(baud16_en),
    .rx_in(rx_in), .rx_data(rx_data), .rx_ready(rx_ready), .rx_error(rx_error),
    .parity_err(parity_err), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  logic [1:0] phase = 2'd0;
  int         cyc = 0;
  always @(posedge clk) begin
    phase <= phase + 2'd1;
    cyc   <= cyc + 1;
  end
  assign baud16_en = (phase == 2'd3);

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;
  exp_t sb[$];

  int   total = 0;
  int   bad = 0;
  int   ready_cnt = 0;
  int   last_ready_cyc = 0;
  int   frame_start_cyc = 0;
  logic prev_ready = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rx_ready) begin
      ready_cnt++;
      last_ready_cyc = cyc;
      total++;
      if (prev_ready !== 1'b0) begin
        bad++;
        $display("FAIL ready_width: rx_ready high %0d consecutive cycles, required 1", 2);
      end
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ready: got rx_ready with data=%h, none expected", rx_data);
      end else begin
        e = sb.pop_front();
        total++;
        if (rx_data !== e.data) begin
          bad++;
          $display("FAIL rx_data: got %h expected %h", rx_data, e.data);
        end
        total++;
        if (parity_err !== e.perr) begin
          bad++;
          $display("FAIL parity_err: got %b expected %b", parity_err, e.perr);
        end
        total++;
        if (frame_err !== e.ferr) begin
          bad++;
          $display("FAIL frame_err: got %b expected %b", frame_err, e.ferr);
        end
        total++;
        if (rx_error !== (e.perr | e.ferr)) begin
          bad++;
          $display("FAIL rx_error: got %b expected %b", rx_error, e.perr | e.ferr);
        end
      end
    end
    prev_ready = rx_ready;
  end

  // Start bit is launched so that the second clock after it is a tick edge,
  // making start detection land exactly SYNC_STAGES clocks after the drive.
  task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen,
                            input bit pbit, input bit s1, input bit s2, input int nstop);
    do @(negedge clk); while (phase != 2'd1);
    frame_start_cyc = cyc;
    rx_in = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx_in = d[i];
      repeat (64) @(negedge clk);
    end
    if (pen) begin
      rx_in = pbit;
      repeat (64) @(negedge clk);
    end
    rx_in = s1;
    repeat (64) @(negedge clk);
    if (nstop == 2) begin
      rx_in = s2;
      repeat (64) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_in = 1'b1;
    ctrl_word = 5'b00011;
    repeat (3) @(negedge clk);
    total++;
    if ({rx_data, rx_ready, rx_error, parity_err, frame_err} !== 12'd0) begin
      bad++;
      $display("FAIL reset_outputs: got data=%h rdy=%b err=%b perr=%b ferr=%b, required all 0",
               rx_data, rx_ready, rx_error, parity_err, frame_err);
    end
    total++;
    if (rx_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: got %b expected 0", rx_busy);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_8n1();
    int r0;
    ctrl_word = 5'b00011;
    r0 = ready_cnt;
    sb.push_back('{8'hA5, 1'b0, 1'b0});
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (ready_cnt - r0 !== 1) begin
      bad++;
      $display("FAIL 8n1_count: got %0d ready pulses expected 1", ready_cnt - r0);
    end
    // ((1+8+0+1)*16-8) ticks * 4 clk + SYNC_STAGES + 1
    total++;
    if (last_ready_cyc - frame_start_cyc !== 611) begin
      bad++;
      $display("FAIL 8n1_latency: got %0d clk expected 611", last_ready_cyc - frame_start_cyc);
    end
    total++;
    if (rx_busy !== 1'b0) begin
      bad++;
      $display("FAIL 8n1_busy_after: got %b expected 0", rx_busy);
    end
  endtask

  task automatic test_parity();
    int r0;
    ctrl_word = 5'b11010;       // 7 data bits, even parity, 1 stop
    r0 = ready_cnt;
    sb.push_back('{8'h35, 1'b0, 1'b0});
    send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    rx_in = 1'b1;
    sb.push_back('{8'h35, 1'b1, 1'b0});
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (parity_err !== 1'b1 || rx_error !== 1'b1) begin
      bad++;
      $display("FAIL 7e1_bad_parity: got perr=%b err=%b expected 1 1", parity_err, rx_error);
    end
    ctrl_word = 5'b01011;       // 8 data bits, odd parity: A5 has four ones
    sb.push_back('{8'hA5, 1'b0, 1'b0});
    send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (ready_cnt - r0 !== 3) begin
      bad++;
      $display("FAIL parity_count: got %0d ready pulses expected 3", ready_cnt - r0);
    end
  endtask

  task automatic test_break();
    int r0;
    ctrl_word = 5'b00011;
    r0 = ready_cnt;
    sb.push_back('{8'h00, 1'b0, 1'b1});
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    rx_in = 1'b0;
    repeat (3 * 640) @(negedge clk);
    total++;
    if (ready_cnt - r0 !== 1) begin
      bad++;
      $display("FAIL break_count: got %0d ready pulses expected 1", ready_cnt - r0);
    end
    total++;
    if (frame_err !== 1'b1 || rx_data !== 8'h00) begin
      bad++;
      $display("FAIL break_flags: got ferr=%b data=%h expected 1 00", frame_err, rx_data);
    end
    rx_in = 1'b1;
    repeat (64) @(negedge clk);
    sb.push_back('{8'h5A, 1'b0, 1'b0});
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (ready_cnt - r0 !== 2 || rx_error !== 1'b0) begin
      bad++;
      $display("FAIL break_recover: got pulses=%0d err=%b expected 2 0", ready_cnt - r0, rx_error);
    end
  endtask

  task automatic test_glitch();
    int r0;
    bit saw_busy;
    r0 = ready_cnt;
    saw_busy = 1'b0;
    do @(negedge clk); while (phase != 2'd1);
    rx_in = 1'b0;
    repeat (12) @(negedge clk);
    rx_in = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (rx_busy === 1'b1) saw_busy = 1'b1;
    end
    total++;
    if (saw_busy !== 1'b1) begin
      bad++;
      $display("FAIL glitch_busy: busy pulse seen=%b expected 1", saw_busy);
    end
    total++;
    if (ready_cnt !== r0 || rx_busy !== 1'b0) begin
      bad++;
      $display("FAIL glitch_ready: got %0d pulses busy=%b expected 0 0", ready_cnt - r0, rx_busy);
    end
    total++;
    if (rx_data !== 8'h5A || rx_error !== 1'b0) begin
      bad++;
      $display("FAIL glitch_outputs: got data=%h err=%b expected 5a 0", rx_data, rx_error);
    end
  endtask

  task automatic test_reset_midframe();
    int r0;
    ctrl_word = 5'b00011;
    r0 = ready_cnt;
    do @(negedge clk); while (phase != 2'd1);
    rx_in = 1'b0;
    repeat (64) @(negedge clk);
    rx_in = 1'b1;
    repeat (4 * 64 + 16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({rx_data, rx_ready, rx_error, parity_err, frame_err, rx_busy} !== 13'd0) begin
      bad++;
      $display("FAIL midframe_reset: got data=%h rdy=%b err=%b perr=%b ferr=%b busy=%b, required 0",
               rx_data, rx_ready, rx_error, parity_err, frame_err, rx_busy);
    end
    repeat (320) @(negedge clk);
    total++;
    if (ready_cnt !== r0) begin
      bad++;
      $display("FAIL midframe_noready: got %0d pulses expected 0", ready_cnt - r0);
    end
    sb.push_back('{8'h3C, 1'b0, 1'b0});
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (ready_cnt - r0 !== 1) begin
      bad++;
      $display("FAIL after_reset_frame: got %0d pulses expected 1", ready_cnt - r0);
    end
  endtask

  task automatic test_5n2();
    int r0;
    ctrl_word = 5'b00100;
    r0 = ready_cnt;
    sb.push_back('{8'h1F, 1'b0, 1'b0});
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, 1'b1, 2);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    // ((1+5+0+2)*16-8) ticks * 4 clk + SYNC_STAGES + 1
    total++;
    if (last_ready_cyc - frame_start_cyc !== 483) begin
      bad++;
      $display("FAIL 5n2_latency: got %0d clk expected 483", last_ready_cyc - frame_start_cyc);
    end
    sb.push_back('{8'h1F, 1'b0, 1'b1});
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (ready_cnt - r0 !== 2 || frame_err !== 1'b1) begin
      bad++;
      $display("FAIL 5n2_second_stop: got pulses=%0d ferr=%b expected 2 1", ready_cnt - r0, frame_err);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_break();
    test_glitch();
    test_reset_midframe();
    test_5n2();
    repeat (20) @(negedge clk);
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL missing_ready: %0d expected frames never completed, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
